// File: rtl/talon_stock_engine.sv
// Talon/stock draw-pile engine for one solitaire game: load, draw-N, take and auto-recycle.
// Optional recycle limit is compiled in with `define TALON_STOCK_RECYCLE_LIMIT_EN.
module talon_stock_engine #(
    parameter int CARD_SIZE    = 6,
    parameter int PILE_DEPTH   = 24,
    parameter int DRAW_COUNT   = 1,
    parameter int SZW          = $clog2(PILE_DEPTH + 1),
    parameter int MAX_RECYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_valid,
    input  logic [PILE_DEPTH*CARD_SIZE-1:0] load_pile,
    input  logic [SZW-1:0]                  load_size,
    input  logic                            draw_req,
    input  logic                            take_req,
    output logic [PILE_DEPTH*CARD_SIZE-1:0] talon_pile,
    output logic [PILE_DEPTH*CARD_SIZE-1:0] stock_pile,
    output logic [SZW-1:0]                  talon_size,
    output logic [SZW-1:0]                  stock_size,
    output logic [CARD_SIZE-1:0]            top_card,
    output logic [SZW-1:0]                  recycle_count,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);
    typedef enum logic [1:0] {IDLE, DRAW, RECYCLE} state_t;
    typedef logic [PILE_DEPTH-1:0][CARD_SIZE-1:0] pile_t;

    localparam logic [SZW-1:0] ONE      = SZW'(1);
    localparam logic [SZW-1:0] DEPTH_SZ = SZW'(PILE_DEPTH);
    localparam logic [SZW-1:0] DRAW_K   = SZW'(DRAW_COUNT);

    state_t         state_reg;
    pile_t          talon_reg;
    pile_t          stock_reg;
    pile_t          load_masked;
    logic [SZW-1:0] talon_size_reg;
    logic [SZW-1:0] stock_size_reg;
    logic [SZW-1:0] recycle_reg;
    logic [SZW-1:0] cnt_reg;
    logic           done_reg;
    logic           err_reg;

    logic [SZW-1:0] talon_top;
    logic [SZW-1:0] stock_top;
    logic [SZW-1:0] draw_moves;
    logic [SZW-1:0] recycle_next;
    logic           recycle_blocked;

    genvar gi;

    if (DRAW_COUNT < 1 || DRAW_COUNT > PILE_DEPTH || MAX_RECYCLES < 0) begin : g_param_check
        $error("talon_stock_engine: DRAW_COUNT must lie in 1..PILE_DEPTH and MAX_RECYCLES >= 0");
    end

    // Entries above load_size are forced to 0 so unused pile slots always read as "no card".
    for (gi = 0; gi < PILE_DEPTH; gi++) begin : g_load_mask
        assign load_masked[gi] = (SZW'(gi) < load_size) ? load_pile[gi*CARD_SIZE +: CARD_SIZE]
                                                         : '0;
    end

    assign talon_top    = talon_size_reg - ONE;
    assign stock_top    = stock_size_reg - ONE;
    assign draw_moves   = (talon_size_reg < DRAW_K) ? talon_size_reg : DRAW_K;
    assign recycle_next = (recycle_reg == '1) ? recycle_reg : recycle_reg + ONE;

`ifdef TALON_STOCK_RECYCLE_LIMIT_EN
    assign recycle_blocked = (recycle_reg == SZW'(MAX_RECYCLES));
`else
    assign recycle_blocked = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            talon_reg      <= '0;
            stock_reg      <= '0;
            talon_size_reg <= '0;
            stock_size_reg <= '0;
            recycle_reg    <= '0;
            cnt_reg        <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load_valid) begin
                        if (load_size > DEPTH_SZ) begin
                            err_reg <= 1'b1;
                        end else begin
                            talon_reg      <= load_masked;
                            talon_size_reg <= load_size;
                            stock_reg      <= '0;
                            stock_size_reg <= '0;
                            recycle_reg    <= '0;
                            done_reg       <= 1'b1;
                        end
                    end else if (take_req) begin
                        if (stock_size_reg == '0) begin
                            err_reg <= 1'b1;
                        end else begin
                            stock_reg[stock_top] <= '0;
                            stock_size_reg       <= stock_top;
                            done_reg             <= 1'b1;
                        end
                    end else if (draw_req) begin
                        if (talon_size_reg != '0) begin
                            state_reg <= DRAW;
                            cnt_reg   <= draw_moves;
                        end else if (stock_size_reg != '0 && !recycle_blocked) begin
                            state_reg <= RECYCLE;
                            cnt_reg   <= stock_size_reg;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                DRAW: begin
                    stock_reg[stock_size_reg] <= talon_reg[talon_top];
                    talon_reg[talon_top]      <= '0;
                    talon_size_reg            <= talon_top;
                    stock_size_reg            <= stock_size_reg + ONE;
                    cnt_reg                   <= cnt_reg - ONE;
                    if (cnt_reg == ONE) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                RECYCLE: begin
                    // Popping stock onto talon reverses order, restoring the original draw order.
                    talon_reg[talon_size_reg] <= stock_reg[stock_top];
                    stock_reg[stock_top]      <= '0;
                    stock_size_reg            <= stock_top;
                    talon_size_reg            <= talon_size_reg + ONE;
                    cnt_reg                   <= cnt_reg - ONE;
                    if (cnt_reg == ONE) begin
                        state_reg   <= IDLE;
                        recycle_reg <= recycle_next;
                        done_reg    <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign talon_pile    = talon_reg;
    assign stock_pile    = stock_reg;
    assign talon_size    = talon_size_reg;
    assign stock_size    = stock_size_reg;
    assign recycle_count = recycle_reg;
    assign top_card      = (stock_size_reg == '0) ? '0 : stock_reg[stock_top];
    assign busy          = (state_reg != IDLE);
    assign done          = done_reg;
    assign err           = err_reg;

endmodule
